mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter that drives the 2-bit select of the 4-to-1 data-flow multiplexer stage. It takes four channel requests, grants one channel at a time, and presents the grant as a registered `sel[1:0]` and a `sel_valid` qualifier. Grants are fair and rotating. A grant is held until the consumer signals `done`, until the granted requester drops, or, optionally, until a hold timeout expires.

## Interface
- `HOLD_CYCLES`, default 16: maximum cycles a grant may be held when the timeout is compiled in; legal range 2..256.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  per-channel request, level-sensitive; bit n = channel n.
- `done`  input  1  consumer pulse: current transfer complete, release grant.
- `sel`  output  2  registered mux select; drives the mux `s[1:0]`.
- `grant`  output  4  registered one-hot grant; all zero when idle.
- `sel_valid`  output  1  high while a grant is active; downstream ignores mux output when low.

## Operation
- Reset values:
  - `sel`=2'd0, `grant`=4'b0000, `sel_valid`=0.
  - Internal `last`=2'd3, so the first search starts at channel 0.
  - State is IDLE; hold counter is 0.
- States:
  - IDLE: no grant.
  - GRANT: one channel owns the mux.
- Priority pick (combinational):
  - Search `req` starting at `last+1` mod 4, ascending with wrap.
  - The first set bit wins.
  - The current owner is therefore lowest priority.
- IDLE → GRANT when `req` ≠ 0:
  - Register `grant`=onehot(winner), `sel`=winner, `sel_valid`=1.
  - Update `last`=winner.
- GRANT release condition: `done`=1, or `req[sel]`=0, or timeout.
  - Coincident causes produce a single release.
- On release:
  - If `req` ≠ 0 in the release cycle, re-pick using the updated `last` and go GRANT with the new winner. This is a back-to-back handoff with no idle cycle.
  - The same channel may be re-granted only if it is the sole requester.
  - Otherwise go to IDLE: `grant`=0, `sel_valid`=0, and `sel` holds its last value.
- `done` while IDLE is ignored.
- `req` changes of non-owners during GRANT do not affect the current grant.
- Reset asserted mid-grant immediately forces all reset values, asynchronously, regardless of state.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge k gives `sel_valid`/`sel` valid after edge k.
- Release to next grant: 1 cycle; the release edge loads the new grant.
- `sel` changes only on a grant edge, so it is glitch-free for the combinational mux.
- Hold counter behaviour:
  - Clears on every grant edge.
  - Increments each GRANT cycle.
  - Width is $clog2(HOLD_CYCLES).
  - Timeout fires in the cycle where the counter equals HOLD_CYCLES-1, so a grant lasts at most HOLD_CYCLES cycles.

## Configuration
- Macro `MUX_ARB_TIMEOUT_EN`:
  - Defined: the hold counter and forced release after HOLD_CYCLES cycles are present.
  - Undefined: the counter is removed; a grant is held indefinitely until `done` or the owner's `req` drops. `HOLD_CYCLES` is unused.

## Structure
- Shared package `mux_arb_pkg` holds:
  - `NUM_CH`=4 and `SEL_W`=2.
  - The state typedef (IDLE, GRANT).
  - The one-hot encode function.
- Sub-module `rr_priority_pick`:
  - Purely combinational.
  - Inputs: `req[3:0]`, `last[1:0]`.
  - Outputs: `any`, `winner[1:0]`.
- The top level contains the FSM, output registers, `last` pointer and optional hold counter.

## Test plan
- Reset → `sel`=0, `grant`=0000, `sel_valid`=0. Then `req`=0100 → one cycle later `grant`=0100, `sel`=2, `sel_valid`=1.
- Fairness:
  - Stimulus: `req`=1111 held, with `done` pulsed every 3 cycles.
  - Required: grants 0001, 0010, 0100, 1000, 0001, … with a handoff on the edge after each `done` and `sel_valid` never dropping.
- Owner drop:
  - Stimulus: channel 1 granted, then `req`=0000.
  - Required: next edge `sel_valid`=0, `grant`=0000, `sel` stays 1. Then `req`=0011 → grant 0001, since search starts at channel 2 and wraps.
- Simultaneous release:
  - Stimulus: `done`=1 and the owner's `req` drop in the same cycle, with `req`=1000 remaining.
  - Required: exactly one handoff, to channel 3, on the next edge.
- Timeout (`MUX_ARB_TIMEOUT_EN`, `HOLD_CYCLES`=4):
  - Stimulus: `req`=0011 held, no `done`.
  - Required: channel 0 granted for exactly 4 cycles, then channel 1 for 4 cycles, alternating.
  - Without the macro, channel 0 is held for more than 100 cycles.
- Async reset:
  - Stimulus: assert `rst_n`=0 mid-cycle during a grant.
  - Required: outputs clear immediately without a clock edge. After release with `req`=1111, the first grant is 0001.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux select arbiter:
// channel count, select width, FSM state type and one-hot encoder.
package mux_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Convert a channel index into a one-hot grant vector
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] base;
        base = {{(NUM_CH-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: searches req starting one past the
// last granted channel, ascending with wrap, so the previous owner has
// the lowest priority.
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic              any,
    output logic [SEL_W-1:0]  winner
);

    logic [SEL_W-1:0] idx_s;

    // First requesting channel after last, wrapping back to last itself
    always_comb begin
        any    = 1'b0;
        winner = last;
        idx_s  = last;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s = last + SEL_W'(i);
            if (!any && req[idx_s]) begin
                any    = 1'b1;
                winner = idx_s;
            end else begin
                any    = any;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// Grant is held until done, until the owner drops its request, or
// (when MUX_ARB_TIMEOUT_EN is defined) until HOLD_CYCLES cycles elapse.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              sel_valid
);

    if ((HOLD_CYCLES < 2) || (HOLD_CYCLES > 256)) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 2..256");
    end

    state_t            state_r;
    logic [SEL_W-1:0]  sel_r;
    logic [NUM_CH-1:0] grant_r;
    logic              sel_valid_r;
    logic [SEL_W-1:0]  last_r;

    logic              pick_any_s;
    logic [SEL_W-1:0]  pick_winner_s;
    logic              timeout_s;
    logic              release_s;
    logic              load_s;

    rr_priority_pick u_pick (
        .req    (req),
        .last   (last_r),
        .any    (pick_any_s),
        .winner (pick_winner_s)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_CYCLES);

    logic [CNT_W-1:0] hold_cnt_r;

    // Hold counter: cleared on each grant edge, counts cycles spent in GRANT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == GRANT) begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`endif

    // Release and grant-load decisions for the current cycle
    always_comb begin
        timeout_s = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        timeout_s = (hold_cnt_r == CNT_W'(HOLD_CYCLES - 1));
`endif
        if (state_r == GRANT) begin
            release_s = done | ~req[sel_r] | timeout_s;
        end else begin
            release_s = 1'b0;
        end
        if ((state_r == IDLE) || release_s) begin
            load_s = pick_any_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Arbiter FSM with registered select, grant and valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sel_r       <= 2'd0;
            grant_r     <= 4'b0000;
            sel_valid_r <= 1'b0;
            last_r      <= 2'd3;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r     <= GRANT;
                        sel_r       <= pick_winner_s;
                        grant_r     <= onehot(pick_winner_s);
                        sel_valid_r <= 1'b1;
                        last_r      <= pick_winner_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                GRANT: begin
                    if (load_s) begin
                        state_r     <= GRANT;
                        sel_r       <= pick_winner_s;
                        grant_r     <= onehot(pick_winner_s);
                        sel_valid_r <= 1'b1;
                        last_r      <= pick_winner_s;
                    end else if (release_s) begin
                        state_r     <= IDLE;
                        grant_r     <= 4'b0000;
                        sel_valid_r <= 1'b0;
                    end else begin
                        state_r     <= GRANT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    grant_r     <= 4'b0000;
                    sel_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign grant     = grant_r;
    assign sel_valid = sel_valid_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed vector table plus
// hand-written fairness, async-reset and hold-timeout sequences.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       sel_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .grant     (grant),
        .sel_valid (sel_valid)
    );

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic v);
        chk({name, "_grant"}, {4'b0000, grant}, {4'b0000, g});
        chk({name, "_sel"}, {6'b000000, sel}, {6'b000000, s});
        chk({name, "_valid"}, {7'b0000000, sel_valid}, {7'b0000000, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[4]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[5]  = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        vecs[9]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[11] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[13] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[14] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};

        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].s, vecs[i].v);
        end

        // async reset in the middle of a grant
        @(negedge clk);
        req  = 4'b0100;
        done = 1'b0;
        tick();
        chk_out("pre_async", 4'b0100, 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 4'b0001, 2'd0, 1'b1);

        // fairness: all request, done pulsed every third cycle
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                done = (c == 2) ? 1'b1 : 1'b0;
                tick();
                if (c < 2) begin
                    chk_out($sformatf("fair%0d_%0d", k, c), 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
                end else begin
                    chk_out($sformatf("fair%0d_h", k), 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1);
                end
            end
        end
        @(negedge clk);
        done = 1'b0;
        req  = 4'b0000;

        // hold timeout behaviour
        do_reset();
        @(negedge clk);
        req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_out($sformatf("tmo%0d", k), 4'b0001 << ((k / 4) % 2), 2'((k / 4) % 2), 1'b1);
        end
`else
        for (int k = 0; k < 120; k++) begin
            tick();
            chk_out($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
